// File: rtl/multi_tone_sweeper.sv
// multi_tone_sweeper: multi-channel square-wave tone generator with a
// runtime-programmable half-period per channel and an optional periodic
// linear sweep (up-wrap or bounce) between a start and a limit bound.
// Optional build macro MULTI_TONE_SWEEPER_STATUS_EN adds the sweep_evt
// output, which pulses for one cycle after a sweep step on which a channel
// wrapped or reversed direction.
module multi_tone_sweeper #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned SWEEP_DIV = 512
) (
    input  logic                                           clock,
    input  logic                                           reset_n,
    input  logic                                           cfg_valid,
    output logic                                           cfg_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_chan,
    input  logic [1:0]                                     cfg_mode,
    input  logic [CNT_W-1:0]                               cfg_start,
    input  logic [CNT_W-1:0]                               cfg_limit,
    output logic [CHANNELS-1:0]                            tone_out,
    output logic [$clog2(CHANNELS+1)-1:0]                  mix_out
`ifdef MULTI_TONE_SWEEPER_STATUS_EN
    ,
    output logic [CHANNELS-1:0]                            sweep_evt
`endif
);

    localparam int unsigned CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned MIX_W  = $clog2(CHANNELS + 1);
    localparam int unsigned PRE_W  = $clog2(SWEEP_DIV);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SWEEP_DIV - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_WRAP   = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Sweep prescaler and config handshake
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             sweep_tick;
    logic             ready_d;
    logic             cfg_fire;

    // Per-channel state
    logic [1:0]       mode_q  [CHANNELS];
    logic [1:0]       mode_d  [CHANNELS];
    logic [CNT_W-1:0] hp_q    [CHANNELS];
    logic [CNT_W-1:0] hp_d    [CHANNELS];
    logic [CNT_W-1:0] start_q [CHANNELS];
    logic [CNT_W-1:0] start_d [CHANNELS];
    logic [CNT_W-1:0] limit_q [CHANNELS];
    logic [CNT_W-1:0] limit_d [CHANNELS];
    logic [CNT_W-1:0] cnt_q   [CHANNELS];
    logic [CNT_W-1:0] cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] dir_q;
    logic [CHANNELS-1:0] dir_d;
    logic [CHANNELS-1:0] tone_d;
    logic [MIX_W-1:0]    mix_d;

    // The ready register predicts the tick one cycle ahead, so cfg_ready is
    // low exactly during the sweep_tick cycle and never overlaps a sweep step.
    assign sweep_tick = (pre_q == PRE_LAST);
    assign pre_d      = sweep_tick ? '0 : pre_q + PRE_W'(1);
    assign ready_d    = (pre_d != PRE_LAST);
    assign cfg_fire   = cfg_valid && cfg_ready;

    // Population count of the current tone vector, registered below
    always_comb begin
        mix_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            mix_d = mix_d + MIX_W'(tone_out[c]);
        end
    end

    // Per-channel next state: tone counter, sweep step, then config override
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            mode_d[c]  = mode_q[c];
            hp_d[c]    = hp_q[c];
            start_d[c] = start_q[c];
            limit_d[c] = limit_q[c];
            cnt_d[c]   = cnt_q[c];
            dir_d[c]   = dir_q[c];
            tone_d[c]  = tone_out[c];

            // >= compare lets a shrinking half-period take effect at once
            if ((mode_q[c] != MODE_OFF) && (hp_q[c] >= TWO)) begin
                if (cnt_q[c] >= (hp_q[c] - ONE)) begin
                    cnt_d[c]  = '0;
                    tone_d[c] = ~tone_out[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + ONE;
                end
            end else begin
                cnt_d[c]  = '0;
                tone_d[c] = 1'b0;
            end

            if (sweep_tick && mode_q[c][1]) begin
                if (limit_q[c] <= start_q[c]) begin
                    hp_d[c] = start_q[c];
                end else if (mode_q[c] == MODE_WRAP) begin
                    hp_d[c] = (hp_q[c] >= limit_q[c]) ? start_q[c] : hp_q[c] + ONE;
                end else if (dir_q[c] == DIR_UP) begin
                    if (hp_q[c] >= limit_q[c]) begin
                        dir_d[c] = DIR_DOWN;
                        if (hp_q[c] != start_q[c]) begin
                            hp_d[c] = hp_q[c] - ONE;
                        end
                    end else begin
                        hp_d[c] = hp_q[c] + ONE;
                    end
                end else begin
                    if (hp_q[c] <= start_q[c]) begin
                        dir_d[c] = DIR_UP;
                        if (hp_q[c] != limit_q[c]) begin
                            hp_d[c] = hp_q[c] + ONE;
                        end
                    end else begin
                        hp_d[c] = hp_q[c] - ONE;
                    end
                end
            end

            // Out-of-range channel numbers match nothing and are dropped
            if (cfg_fire && (cfg_chan == CHAN_W'(c))) begin
                mode_d[c]  = cfg_mode;
                start_d[c] = cfg_start;
                limit_d[c] = cfg_limit;
                hp_d[c]    = cfg_start;
                cnt_d[c]   = '0;
                tone_d[c]  = 1'b0;
                dir_d[c]   = DIR_UP;
            end
        end
    end

    // State registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_q     <= '0;
            cfg_ready <= 1'b0;
            tone_out  <= '0;
            mix_out   <= '0;
            dir_q     <= {CHANNELS{DIR_UP}};
            for (int c = 0; c < CHANNELS; c++) begin
                mode_q[c]  <= MODE_OFF;
                hp_q[c]    <= '0;
                start_q[c] <= '0;
                limit_q[c] <= '0;
                cnt_q[c]   <= '0;
            end
        end else begin
            pre_q     <= pre_d;
            cfg_ready <= ready_d;
            tone_out  <= tone_d;
            mix_out   <= mix_d;
            dir_q     <= dir_d;
            for (int c = 0; c < CHANNELS; c++) begin
                mode_q[c]  <= mode_d[c];
                hp_q[c]    <= hp_d[c];
                start_q[c] <= start_d[c];
                limit_q[c] <= limit_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
        end
    end

`ifdef MULTI_TONE_SWEEPER_STATUS_EN
    logic [CHANNELS-1:0] evt_d;

    // A sweep step counts as an event when it wraps (up-wrap) or reverses (bounce)
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            evt_d[c] = 1'b0;
            if (sweep_tick && (limit_q[c] > start_q[c])) begin
                if (mode_q[c] == MODE_WRAP) begin
                    evt_d[c] = (hp_q[c] >= limit_q[c]);
                end else if (mode_q[c] == MODE_BOUNCE) begin
                    evt_d[c] = (dir_q[c] == DIR_UP) ? (hp_q[c] >= limit_q[c])
                                                    : (hp_q[c] <= start_q[c]);
                end
            end
        end
    end

    // One-cycle event pulse, visible the cycle after the sweep tick
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sweep_evt <= '0;
        end else begin
            sweep_evt <= evt_d;
        end
    end
`endif

endmodule

// File: tb/tb_multi_tone_sweeper.sv
// Self-checking bench for multi_tone_sweeper: directed steps plus random
// configuration traffic, checked against a behavioural reference model.
// Build with MULTI_TONE_SWEEPER_STATUS_EN to also check sweep_evt.
module tb_multi_tone_sweeper;

    localparam int CH  = 4;
    localparam int DIV = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_chan;
    logic [1:0]  cfg_mode;
    logic [15:0] cfg_start;
    logic [15:0] cfg_limit;
    logic [CH-1:0] tone_out;
    logic [2:0]  mix_out;
`ifdef MULTI_TONE_SWEEPER_STATUS_EN
    logic [CH-1:0] sweep_evt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state (plain integers)
    int m_mode  [CH];
    int m_hp    [CH];
    int m_start [CH];
    int m_limit [CH];
    int m_cnt   [CH];
    bit m_up    [CH];
    bit m_tone  [CH];
    bit m_evt   [CH];
    int m_mix;
    int m_pre;
    bit m_ready;

    multi_tone_sweeper #(
        .CHANNELS (CH),
        .CNT_W    (16),
        .SWEEP_DIV(DIV)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_chan (cfg_chan),
        .cfg_mode (cfg_mode),
        .cfg_start(cfg_start),
        .cfg_limit(cfg_limit),
        .tone_out (tone_out),
        .mix_out  (mix_out)
`ifdef MULTI_TONE_SWEEPER_STATUS_EN
        ,
        .sweep_evt(sweep_evt)
`endif
    );

    always #5 clock = ~clock;

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_mode[c] = 0; m_hp[c] = 0; m_start[c] = 0; m_limit[c] = 0;
            m_cnt[c] = 0; m_up[c] = 1'b1; m_tone[c] = 1'b0; m_evt[c] = 1'b0;
        end
        m_mix = 0; m_pre = 0; m_ready = 1'b0;
    endfunction

    // One clock edge of the behavioural model, applying the rules directly
    function automatic void model_step();
        bit tick;
        bit fire;
        int nmix;
        if (!reset_n) begin
            model_reset();
            return;
        end
        tick = (m_pre == DIV - 1);
        fire = cfg_valid && m_ready;
        nmix = 0;
        for (int c = 0; c < CH; c++) nmix += int'(m_tone[c]);
        for (int c = 0; c < CH; c++) begin
            bit ev;
            ev = 1'b0;
            if (m_mode[c] != 0 && m_hp[c] >= 2) begin
                if (m_cnt[c] >= m_hp[c] - 1) begin
                    m_cnt[c] = 0;
                    m_tone[c] = !m_tone[c];
                end else begin
                    m_cnt[c]++;
                end
            end else begin
                m_cnt[c] = 0;
                m_tone[c] = 1'b0;
            end
            if (tick && m_mode[c] >= 2) begin
                if (m_limit[c] <= m_start[c]) begin
                    m_hp[c] = m_start[c];
                end else if (m_mode[c] == 2) begin
                    if (m_hp[c] >= m_limit[c]) begin m_hp[c] = m_start[c]; ev = 1'b1; end
                    else m_hp[c]++;
                end else if (m_up[c]) begin
                    if (m_hp[c] >= m_limit[c]) begin
                        m_up[c] = 1'b0; ev = 1'b1;
                        if (m_hp[c] != m_start[c]) m_hp[c]--;
                    end else m_hp[c]++;
                end else begin
                    if (m_hp[c] <= m_start[c]) begin
                        m_up[c] = 1'b1; ev = 1'b1;
                        if (m_hp[c] != m_limit[c]) m_hp[c]++;
                    end else m_hp[c]--;
                end
            end
            if (fire && int'(cfg_chan) == c) begin
                m_mode[c] = int'(cfg_mode); m_start[c] = int'(cfg_start);
                m_limit[c] = int'(cfg_limit); m_hp[c] = int'(cfg_start);
                m_cnt[c] = 0; m_tone[c] = 1'b0; m_up[c] = 1'b1;
            end
            m_evt[c] = ev;
        end
        m_pre = (m_pre + 1) % DIV;
        m_ready = (m_pre != DIV - 1);
        m_mix = nmix;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [CH-1:0] et;
        logic [CH-1:0] ee;
        for (int c = 0; c < CH; c++) begin
            et[c] = m_tone[c];
            ee[c] = m_evt[c];
        end
        check("tone_out", 32'(tone_out), 32'(et));
        check("mix_out", 32'(mix_out), 32'(m_mix));
        check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
`ifdef MULTI_TONE_SWEEPER_STATUS_EN
        check("sweep_evt", 32'(sweep_evt), 32'(ee));
`else
        if (ee != ee) check("evt_unused", 32'(0), 32'(1));
`endif
    endtask

    // Inputs change at negedge; model steps on posedge; outputs checked at negedge
    task automatic cyc();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_all();
    endtask

    task automatic do_cfg(input int ch, input int md, input int st, input int lim);
        bit done;
        done = 1'b0;
        cfg_chan = 2'(ch); cfg_mode = 2'(md);
        cfg_start = 16'(st); cfg_limit = 16'(lim);
        cfg_valid = 1'b1;
        for (int n = 0; n < 4 && !done; n++) begin
            done = cfg_ready;
            cyc();
        end
        cfg_valid = 1'b0;
        total++;
        assert (done) else begin
            bad++;
            $error("FAIL cfg_accept observed=timeout expected=accept ch=%0d", ch);
        end
    endtask

    // Closed-form check of a fixed-mode channel: toggles every hp edges after accept
    task automatic check_fixed(input string tag, input int ch, input int hp, input int n);
        for (int k = 0; k < n; k++) begin
            check(tag, 32'(tone_out[ch]), 32'((k / hp) % 2));
            cyc();
        end
    endtask

    initial begin
        reset_n = 1'b0; cfg_valid = 1'b0; cfg_chan = '0; cfg_mode = '0;
        cfg_start = '0; cfg_limit = '0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_tone", 32'(tone_out), 32'(0));
        check("rst_mix", 32'(mix_out), 32'(0));
        check("rst_ready", 32'(cfg_ready), 32'(0));
        reset_n = 1'b1;
        cyc();
        check("ready_after_rst", 32'(cfg_ready), 32'(1));

        // ch0 fixed, half-period 3
        do_cfg(0, 1, 3, 0);
        check_fixed("fix3", 0, 3, 14);

        // ch1 up-wrap 4..6, ch2 bounce 4..6
        do_cfg(1, 2, 4, 6);
        do_cfg(2, 3, 4, 6);
        repeat (90) cyc();

        // cfg_valid held across a sweep tick
        while (m_pre != DIV - 1) cyc();
        check("ready_tick", 32'(cfg_ready), 32'(0));
        cfg_chan = 2'd3; cfg_mode = 2'd1; cfg_start = 16'd5; cfg_limit = 16'd0;
        cfg_valid = 1'b1;
        cyc();
        check("ready_post_tick", 32'(cfg_ready), 32'(1));
        cyc();
        cfg_valid = 1'b0;
        check_fixed("held_fix5", 3, 5, 16);

        // Mid-count rewrite of a long half-period
        do_cfg(0, 1, 100, 0);
        repeat (50) cyc();
        check("pre_rewrite", 32'(tone_out[0]), 32'(0));
        do_cfg(0, 1, 10, 0);
        check_fixed("rewrite10", 0, 10, 45);

        // Degenerate: hp=1, mode off, and limit<=start in a sweep mode
        do_cfg(3, 1, 1, 0);
        do_cfg(2, 0, 7, 9);
        do_cfg(1, 2, 6, 3);
        for (int k = 0; k < 24; k++) begin
            check("hp1_zero", 32'(tone_out[3]), 32'(0));
            check("off_zero", 32'(tone_out[2]), 32'(0));
            cyc();
        end

        // Random configuration traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cfg_chan  = 2'($urandom_range(0, 3));
                cfg_mode  = 2'($urandom_range(0, 3));
                cfg_start = 16'($urandom_range(0, 9));
                cfg_limit = 16'($urandom_range(0, 12));
                cfg_valid = 1'b1;
            end else begin
                cfg_valid = 1'b0;
            end
            cyc();
        end
        cfg_valid = 1'b0;

        // Asynchronous reset while sweeping
        do_cfg(1, 2, 4, 6);
        do_cfg(2, 3, 2, 5);
        repeat (30) cyc();
        #2 reset_n = 1'b0;
        #1;
        check("async_tone", 32'(tone_out), 32'(0));
        check("async_mix", 32'(mix_out), 32'(0));
        check("async_ready", 32'(cfg_ready), 32'(0));
        model_reset();
        repeat (3) cyc();
        reset_n = 1'b1;
        cyc();
        check("ready_after_async", 32'(cfg_ready), 32'(1));
        repeat (20) cyc();
        check("post_reset_idle", 32'(tone_out), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
